// File: rtl/load_store_unit_if.sv
// Word-organised data memory bus between the load/store unit and the memory.
// The LSU owns address, data, lane enables and strobes; memory answers with ready/rdata.
interface load_store_unit_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_re;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_be, mem_we, mem_re,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_be, mem_we, mem_re,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core load/store into a wait-stated memory transaction
// with byte-lane sizing, alignment faults and a bus timeout; stalls the core meanwhile.
module load_store_unit #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        misaligned,
  output logic        timeout_err,
  load_store_unit_if.master mem
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_next;
  logic        accept, fault, pass, done_ok, done_to;
  logic        aligned;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [7:0]  timer;

  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_unsigned, lat_memtoreg, lat_load;

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        mem_we_q, mem_re_q;

  always_comb begin
    aligned   = 1'b1;
    be        = 4'b1111;
    wdata_rep = writedata;
    case (size)
      2'b00: begin
        be        = 4'b0001 << address[1:0];
        wdata_rep = {4{writedata[7:0]}};
      end
      2'b01: begin
        aligned   = ~address[0];
        be        = 4'b0011 << address[1:0];
        wdata_rep = {2{writedata[15:0]}};
      end
      default: aligned = (address[1:0] == 2'b00);
    endcase
  end

  // Load data uses the request attributes captured at acceptance, not the live inputs.
  always_comb begin
    shifted  = mem.mem_rdata >> {lat_addr[1:0], 3'b000};
    lane_b   = shifted[7:0];
    lane_h   = lat_addr[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    load_val = mem.mem_rdata;
    case (lat_size)
      2'b00:   load_val = lat_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_val = lat_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fault      = 1'b0;
    pass       = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (memread | memwrite) begin
            if (!aligned) begin
              fault = 1'b1;
            end else begin
              accept     = 1'b1;
              state_next = ACCESS;
            end
          end else begin
            pass = 1'b1;
          end
        end
      end
      ACCESS: begin
        // A ready on the final allowed cycle wins over the timeout.
        if (mem.mem_ready) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end else if (timer == TIMEOUT - 8'd1) begin
          done_to    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer        <= 8'd0;
      lat_addr     <= 32'd0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_memtoreg <= 1'b0;
      lat_load     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_be_q     <= 4'd0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      result       <= 32'd0;
      result_valid <= 1'b0;
      misaligned   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      misaligned   <= 1'b0;
      timeout_err  <= 1'b0;

      if (fault) begin
        result_valid <= 1'b1;
        misaligned   <= 1'b1;
        result       <= 32'd0;
      end

      if (pass) begin
        result_valid <= 1'b1;
        result       <= address;
      end

      if (accept) begin
        timer        <= 8'd0;
        lat_addr     <= address;
        lat_size     <= size;
        lat_unsigned <= load_unsigned;
        lat_memtoreg <= memtoreg;
        lat_load     <= ~memwrite;
        mem_addr_q   <= {2'b00, address[31:2]};
        mem_be_q     <= be;
        mem_we_q     <= memwrite;
        mem_re_q     <= ~memwrite;
        if (memwrite) mem_wdata_q <= wdata_rep;
      end

      if (state == ACCESS) timer <= timer + 8'd1;

      if (done_ok) begin
        mem_we_q     <= 1'b0;
        mem_re_q     <= 1'b0;
        result_valid <= 1'b1;
        result       <= (lat_load && lat_memtoreg) ? load_val : lat_addr;
      end

      if (done_to) begin
        mem_we_q     <= 1'b0;
        mem_re_q     <= 1'b0;
        result_valid <= 1'b1;
        timeout_err  <= 1'b1;
        result       <= 32'd0;
      end
    end
  end

  assign stall = ~reset & ((state == ACCESS) | accept);

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_re    = mem_re_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: requests push expected writebacks,
// a negedge monitor pops and compares them whenever result_valid pulses.
module tb_load_store_unit;

  localparam logic [7:0] TMO = 8'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic        memtoreg = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic        misaligned;
  logic        timeout_err;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .memread       (memread),
    .memwrite      (memwrite),
    .memtoreg      (memtoreg),
    .size          (size),
    .load_unsigned (load_unsigned),
    .address       (address),
    .writedata     (writedata),
    .stall         (stall),
    .result        (result),
    .result_valid  (result_valid),
    .misaligned    (misaligned),
    .timeout_err   (timeout_err),
    .mem           (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        mis;
    logic        tmo;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t monEntry;
  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  // Every result_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (result_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result_valid", 32'd1, 32'd0);
        end else begin
          monEntry = sb.pop_front();
          checkOutput("result", result, monEntry.res);
          checkOutput("misaligned", {31'd0, misaligned}, {31'd0, monEntry.mis});
          checkOutput("timeout_err", {31'd0, timeout_err}, {31'd0, monEntry.tmo});
        end
      end else if (misaligned || timeout_err) begin
        checkOutput("stray_flag", {30'd0, misaligned, timeout_err}, 32'd0);
      end
    end
  end

  task automatic applyStimulus(
    input logic rd, input logic wr, input logic m2r, input logic [1:0] sz, input logic lu,
    input logic [31:0] addr, input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
    input logic [31:0] expRes, input logic expMis, input logic expTmo,
    input logic [3:0] expBe, input logic [31:0] expWdata);
    int  cnt;
    int  expCycles;
    logic access;
    access = (rd | wr) & ~expMis;
    expCycles = expTmo ? int'(TMO) : waits + 1;
    @(negedge clk);
    req_valid = 1'b1; memread = rd; memwrite = wr; memtoreg = m2r; size = sz;
    load_unsigned = lu; address = addr; writedata = wdata; bus.mem_ready = 1'b0;
    sb.push_back('{expRes, expMis, expTmo});
    #1 checkOutput("stall_on_request", {31'd0, stall}, {31'd0, access});
    if (!access) begin
      @(negedge clk);
      req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
      checkOutput("result_valid_next_cycle", {31'd0, result_valid}, 32'd1);
      checkOutput("no_strobe", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
      #1 checkOutput("stall_idle", {31'd0, stall}, 32'd0);
    end else begin
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!(bus.mem_we || bus.mem_re)) break;
        cnt++;
        checkOutput("mem_addr", bus.mem_addr, {2'b00, addr[31:2]});
        checkOutput("mem_be", {28'd0, bus.mem_be}, {28'd0, expBe});
        checkOutput("mem_we", {31'd0, bus.mem_we}, {31'd0, wr});
        checkOutput("mem_re", {31'd0, bus.mem_re}, {31'd0, rd & ~wr});
        checkOutput("stall_access", {31'd0, stall}, 32'd1);
        if (wr) checkOutput("mem_wdata", bus.mem_wdata, expWdata);
        if (cnt > waits) begin
          bus.mem_ready = 1'b1; bus.mem_rdata = rdata;
        end else begin
          bus.mem_ready = 1'b0; bus.mem_rdata = $urandom;
        end
      end
      bus.mem_ready = 1'b0;
      req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
      checkOutput("strobe_cycles", cnt, expCycles);
      checkOutput("result_valid_done", {31'd0, result_valid}, 32'd1);
      #1 checkOutput("stall_after", {31'd0, stall}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd32;
    logic [1:0]  off;
    logic        lu, half;
    logic [31:0] expRes;
    logic [7:0]  b;
    logic [15:0] h;

    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_result_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("reset_strobes", {26'd0, bus.mem_be, bus.mem_we, bus.mem_re}, 32'd0);
    checkOutput("reset_mem_addr", bus.mem_addr, 32'd0);
    reset = 1'b0;

    // rd, wr, m2r, size, lu, addr, wdata, waits, rdata, expRes, mis, tmo, be, wdata
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 32'h10, 0, 0, 4'b1111, 32'hDEADBEEF);
    applyStimulus(1, 0, 1, 2'b00, 0, 32'h13, 32'h0, 1, 32'h80FF0000, 32'hFFFFFF80, 0, 0, 4'b1000, 32'h0);
    applyStimulus(1, 0, 1, 2'b00, 1, 32'h13, 32'h0, 0, 32'h80FF0000, 32'h00000080, 0, 0, 4'b1000, 32'h0);
    applyStimulus(1, 0, 1, 2'b01, 0, 32'h22, 32'h0, 0, 32'h12345678, 32'h00001234, 0, 0, 4'b1100, 32'h0);
    applyStimulus(1, 0, 1, 2'b01, 0, 32'h21, 32'h0, 0, 32'h12345678, 32'h0, 1, 0, 4'b0000, 32'h0);
    applyStimulus(1, 0, 1, 2'b10, 0, 32'h12, 32'h0, 0, 32'h0, 32'h0, 1, 0, 4'b0000, 32'h0);
    applyStimulus(1, 0, 1, 2'b11, 0, 32'h30, 32'h0, 100, 32'h0, 32'h0, 0, 1, 4'b1111, 32'h0);
    applyStimulus(1, 0, 1, 2'b10, 0, 32'h40, 32'h0, 3, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 4'b1111, 32'h0);
    applyStimulus(0, 0, 1, 2'b10, 0, 32'hABCD, 32'h0, 0, 32'h0, 32'hABCD, 0, 0, 4'b0000, 32'h0);
    applyStimulus(1, 1, 1, 2'b00, 0, 32'h05, 32'h123456A5, 0, 32'hFFFFFFFF, 32'h05, 0, 0, 4'b0010, 32'hA5A5A5A5);
    applyStimulus(0, 1, 0, 2'b01, 0, 32'h06, 32'h0000BEEF, 1, 32'h0, 32'h06, 0, 0, 4'b1100, 32'hBEEFBEEF);
    applyStimulus(1, 0, 0, 2'b10, 0, 32'h44, 32'h0, 0, 32'h11111111, 32'h44, 0, 0, 4'b1111, 32'h0);
    applyStimulus(1, 0, 1, 2'b01, 0, 32'h20, 32'h0, 0, 32'h00008001, 32'hFFFF8001, 0, 0, 4'b0011, 32'h0);

    // Randomised sub-word loads against an independent lane/extension model.
    for (int i = 0; i < 8; i++) begin
      half = 1'($urandom_range(0, 1));
      off  = 2'($urandom_range(0, 3));
      if (half) off[0] = 1'b0;
      lu   = 1'($urandom_range(0, 1));
      rd32 = $urandom;
      b = rd32[8*off +: 8];
      h = rd32[8*off +: 16];
      if (half) expRes = lu ? {16'd0, h} : {{16{h[15]}}, h};
      else      expRes = lu ? {24'd0, b} : {{24{b[7]}}, b};
      applyStimulus(1, 0, 1, {1'b0, half}, lu, 32'h100 + 32'(i * 4) + {30'd0, off}, 32'h0,
                    i % 3, rd32, expRes, 0, 0, half ? (4'b0011 << off) : (4'b0001 << off), 32'h0);
    end

    // Stray memory responses while idle must not produce results.
    @(negedge clk);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_ready_ignored", {31'd0, result_valid}, 32'd0);
    end
    bus.mem_ready = 1'b0;

    // Reset in the second ACCESS cycle aborts the store without a result.
    @(negedge clk);
    req_valid = 1'b1; memwrite = 1'b1; memread = 1'b0; size = 2'b10;
    address = 32'h80; writedata = 32'h11223344;
    @(negedge clk);
    checkOutput("abort_we_cycle1", {31'd0, bus.mem_we}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_we_drop", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("abort_re_drop", {31'd0, bus.mem_re}, 32'd0);
    checkOutput("abort_stall_drop", {31'd0, stall}, 32'd0);
    checkOutput("abort_no_result", {31'd0, result_valid}, 32'd0);
    req_valid = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("post_reset_quiet", {31'd0, result_valid}, 32'd0);
    end
    applyStimulus(1, 0, 1, 2'b10, 0, 32'h84, 32'h0, 1, 32'h0BADF00D, 32'h0BADF00D, 0, 0, 4'b1111, 32'h0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
